// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer for the 5-stage pipeline; generates stage load/flush
// enables, owns the imem/dmem handshakes and keeps stall/redirect performance counters.
`default_nettype none

module pipeline_ctrl #(
   parameter int CNT_WIDTH   = 32,
   parameter int BOOT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 imem_resp,
   input  logic [31:0]          imem_rdata,
   output logic                 imem_read,
   output logic [31:0]          instr_out,
   input  logic                 dmem_read_req,
   input  logic                 dmem_write_req,
   input  logic                 dmem_resp,
   input  logic [31:0]          dmem_rdata,
   output logic                 dmem_read,
   output logic                 dmem_write,
   output logic [31:0]          dmem_rdata_out,
   input  logic [4:0]           id_rs1,
   input  logic [4:0]           id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic [4:0]           ex_rd,
   input  logic                 ex_is_load,
   input  logic                 br_taken,
   output logic                 pc_load,
   output logic                 if_id_load,
   output logic                 id_ex_load,
   output logic                 ex_mem_load,
   output logic                 mem_wb_load,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 pc_sel_redirect,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_count
);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [3:0]           BOOT_LAST = 4'(BOOT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t      state;
   logic [3:0]  boot_cnt;
   logic        imem_done;
   logic        dmem_done;
   logic [31:0] ihold;
   logic [31:0] dhold;

   logic running;
   logic imem_ok;
   logic dmem_ok;
   logic advance;
   logic hazard;
   logic redirect;
   logic ld_stall;

   assign running  = (state == RUN);
   assign imem_ok  = imem_done | imem_resp;
   assign dmem_ok  = ~(dmem_read_req | dmem_write_req) | dmem_done | dmem_resp;
   assign advance  = running & imem_ok & dmem_ok;

   assign hazard   = ex_is_load & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
   // A redirect squashes the ID instruction, so its hazard is irrelevant.
   assign redirect = advance & br_taken;
   assign ld_stall = advance & ~br_taken & hazard;

   assign imem_read  = running & ~imem_done;
   assign dmem_read  = running & dmem_read_req  & ~dmem_done;
   assign dmem_write = running & dmem_write_req & ~dmem_done;

   assign instr_out      = imem_done ? ihold : imem_rdata;
   assign dmem_rdata_out = dmem_done ? dhold : dmem_rdata;

   assign pc_load         = advance & ~ld_stall;
   assign if_id_load      = advance & ~ld_stall;
   assign id_ex_load      = advance;
   assign ex_mem_load     = advance;
   assign mem_wb_load     = advance;
   assign if_id_flush     = redirect;
   assign id_ex_flush     = redirect | ld_stall;
   assign pc_sel_redirect = redirect;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= BOOT;
         boot_cnt     <= 4'd0;
         imem_done    <= 1'b0;
         dmem_done    <= 1'b0;
         ihold        <= 32'd0;
         dhold        <= 32'd0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         case (state)
            BOOT: begin
               if (boot_cnt == BOOT_LAST) begin
                  state <= RUN;
               end else begin
                  boot_cnt <= boot_cnt + 4'd1;
               end
            end
            RUN: begin
               if (!advance) begin
                  stall_cycles <= stall_cycles + CNT_ONE;
                  if (imem_resp && !imem_done) begin
                     imem_done <= 1'b1;
                     ihold     <= imem_rdata;
                  end
                  if (dmem_resp && !dmem_done) begin
                     dmem_done <= 1'b1;
                     dhold     <= dmem_rdata;
                  end
               end else if (br_taken) begin
                  imem_done   <= 1'b0;
                  dmem_done   <= 1'b0;
                  flush_count <= flush_count + CNT_ONE;
               end else if (hazard) begin
                  // IF holds: keep the fetched word so the stalled slot needs no re-fetch.
                  stall_cycles <= stall_cycles + CNT_ONE;
                  imem_done    <= 1'b1;
                  dmem_done    <= 1'b0;
                  if (!imem_done) begin
                     ihold <= imem_rdata;
                  end
               end else begin
                  imem_done <= 1'b0;
                  dmem_done <= 1'b0;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table through a scoreboard queue,
// plus hand-written boot and asynchronous-reset sequences.
`default_nettype none

module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_resp = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_read;
   logic [31:0] instr_out;
   logic        dmem_read_req = 1'b0;
   logic        dmem_write_req = 1'b0;
   logic        dmem_resp = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_rdata_out;
   logic [4:0]  id_rs1 = 5'd0;
   logic [4:0]  id_rs2 = 5'd0;
   logic        id_uses_rs1 = 1'b0;
   logic        id_uses_rs2 = 1'b0;
   logic [4:0]  ex_rd = 5'd0;
   logic        ex_is_load = 1'b0;
   logic        br_taken = 1'b0;
   logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic        if_id_flush, id_ex_flush, pc_sel_redirect;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_ctrl #(.CNT_WIDTH(32), .BOOT_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata), .imem_read(imem_read), .instr_out(instr_out),
      .dmem_read_req(dmem_read_req), .dmem_write_req(dmem_write_req), .dmem_resp(dmem_resp),
      .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_rdata_out(dmem_rdata_out),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_taken(br_taken),
      .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
      .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pc_sel_redirect(pc_sel_redirect),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   // ctrl = {imem_read, dmem_read, dmem_write, pc, if_id, id_ex, ex_mem, mem_wb loads,
   //         if_id_flush, id_ex_flush, pc_sel_redirect}
   typedef struct {
      logic        im_resp;
      logic [31:0] im_data;
      logic        rd_req;
      logic        wr_req;
      logic        dm_resp;
      logic [31:0] dm_data;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        use1;
      logic        use2;
      logic [4:0]  exrd;
      logic        exld;
      logic        br;
      logic [10:0] ctrl;
      logic [31:0] instr;
      logic [31:0] rdat;
      logic [31:0] stall;
      logic [31:0] fcnt;
   } vec_t;

   localparam int NVEC = 19;
   vec_t tbl [NVEC];
   vec_t exp_q [$];

   function automatic logic [10:0] ctrl_now();
      return {imem_read, dmem_read, dmem_write, pc_load, if_id_load, id_ex_load,
              ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush, pc_sel_redirect};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      imem_resp      = v.im_resp;
      imem_rdata     = v.im_data;
      dmem_read_req  = v.rd_req;
      dmem_write_req = v.wr_req;
      dmem_resp      = v.dm_resp;
      dmem_rdata     = v.dm_data;
      id_rs1         = v.rs1;
      id_rs2         = v.rs2;
      id_uses_rs1    = v.use1;
      id_uses_rs2    = v.use2;
      ex_rd          = v.exrd;
      ex_is_load     = v.exld;
      br_taken       = v.br;
   endtask

   task automatic step(input vec_t v, input int idx);
      vec_t e;
      drive(v);
      exp_q.push_back(v);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1 (vec %0d)", idx);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("v%0d.ctrl", idx), {21'd0, ctrl_now()}, {21'd0, e.ctrl});
         check($sformatf("v%0d.instr_out", idx), instr_out, e.instr);
         check($sformatf("v%0d.dmem_rdata_out", idx), dmem_rdata_out, e.rdat);
         check($sformatf("v%0d.stall_cycles", idx), stall_cycles, e.stall);
         check($sformatf("v%0d.flush_count", idx), flush_count, e.fcnt);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t z;
      //            imr   imdata        rd    wr    dmr   dmdata        rs1   rs2   u1    u2    exrd  exld  br    ctrl              instr         rdat          stall  fcnt
      tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b000_00000_000, 32'h0,        32'h0,        32'd0, 32'd0};
      tbl[1]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b000_00000_000, 32'hDEADBEEF, 32'h0,        32'd0, 32'd0};
      tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b100_00000_000, 32'h0,        32'h0,        32'd0, 32'd0};
      tbl[3]  = '{1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b100_11111_000, 32'h00000013, 32'h0,        32'd1, 32'd0};
      tbl[4]  = '{1'b1, 32'h00A00093, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b110_00000_000, 32'h00A00093, 32'h0,        32'd1, 32'd0};
      tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b010_00000_000, 32'h00A00093, 32'h0,        32'd2, 32'd0};
      tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b010_00000_000, 32'h00A00093, 32'h0,        32'd3, 32'd0};
      tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b010_11111_000, 32'h00A00093, 32'hCAFEF00D, 32'd4, 32'd0};
      tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h11112222, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b101_00000_000, 32'h0,        32'h11112222, 32'd4, 32'd0};
      tbl[9]  = '{1'b1, 32'h00000033, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b100_11111_000, 32'h00000033, 32'h11112222, 32'd5, 32'd0};
      tbl[10] = '{1'b1, 32'h00500113, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 11'b100_00111_010, 32'h00500113, 32'h0,        32'd5, 32'd0};
      tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b000_11111_000, 32'h00500113, 32'h0,        32'd6, 32'd0};
      tbl[12] = '{1'b1, 32'h00000044, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 11'b100_11111_000, 32'h00000044, 32'h0,        32'd6, 32'd0};
      tbl[13] = '{1'b1, 32'h00000055, 1'b0, 1'b0, 1'b0, 32'h0,        5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 11'b100_11111_000, 32'h00000055, 32'h0,        32'd6, 32'd0};
      tbl[14] = '{1'b1, 32'h00000066, 1'b1, 1'b0, 1'b1, 32'h00000077, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 11'b110_11111_111, 32'h00000066, 32'h00000077, 32'd6, 32'd0};
      tbl[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 11'b100_00000_000, 32'h0,        32'h0,        32'd6, 32'd1};
      tbl[16] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 11'b100_00000_000, 32'h0,        32'h0,        32'd7, 32'd1};
      tbl[17] = '{1'b1, 32'h00000088, 1'b0, 1'b0, 1'b0, 32'h0,        5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 11'b100_00111_010, 32'h00000088, 32'h0,        32'd8, 32'd1};
      tbl[18] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 11'b010_00000_000, 32'h00000088, 32'h0,        32'd9, 32'd1};
      z = tbl[0];

      // Reset asserted from time 0; release just after an edge, then BOOT begins.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i], i);
      end

      // Held fetch word is outstanding (imem_done=1) and stall_cycles=10: reset mid-cycle.
      imem_rdata = 32'd0;
      dmem_rdata = 32'd0;
      #2;
      rst = 1'b0;
      #1;
      check("async_rst.ctrl", {21'd0, ctrl_now()}, 32'd0);
      check("async_rst.instr_out", instr_out, 32'd0);
      check("async_rst.dmem_rdata_out", dmem_rdata_out, 32'd0);
      check("async_rst.stall_cycles", stall_cycles, 32'd0);
      check("async_rst.flush_count", flush_count, 32'd0);

      drive(z);
      @(posedge clk);
      #1;
      rst = 1'b1;
      // Back in BOOT: two fetch-free cycles, then fetching resumes.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("reboot%0d.imem_read", k), {31'd0, imem_read}, (k >= 2) ? 32'd1 : 32'd0);
         check($sformatf("reboot%0d.loads", k),
               {27'd0, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
